// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler sharing one fixed-latency AES wrapper among NUM_REQ requesters, with an ID-tagged response FIFO.
// Define AES_SCHED_CHECK_EN to compare core_valid_out against the tag pipe and latch err_sticky on mismatch.
module aes_req_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int CORE_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_text,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_key,
  input  logic [NUM_REQ-1:0]            req_flag,
  output logic                          core_valid_in,
  output logic [DATA_WIDTH-1:0]         core_plan_text_128,
  output logic [DATA_WIDTH-1:0]         core_cipher_key_128,
  output logic                          core_flag,
  input  logic [DATA_WIDTH-1:0]         core_cipher_text_128,
  input  logic                          core_valid_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_flag,
  output logic                          err_sticky
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]         rr_ptr;
  logic                    grant_vld;
  logic [ID_W-1:0]         grant_id;
  logic                    credit_ok;
  int                      inflight;
  int                      arb_idx;
  logic [ID_W-1:0]         core_id_p0;
  logic [CORE_LATENCY-1:0] tag_vld_p1;
  logic [CORE_LATENCY-1:0] tag_flag_p1;
  logic [ID_W-1:0]         tag_id_p1 [CORE_LATENCY];
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]         fifo_id [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_flag;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic                    push;
  logic                    pop;

  // Everything between accept and FIFO write holds a credit: the core input register plus the tag pipe.
  always_comb begin
    inflight  = int'(core_valid_in) + $countones(tag_vld_p1);
    credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (credit_ok && !grant_vld && req_valid[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(arb_idx);
      end
    end
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;

  // Stage p0: wrapper input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr              <= '0;
      core_valid_in       <= 1'b0;
      core_plan_text_128  <= '0;
      core_cipher_key_128 <= '0;
      core_flag           <= 1'b0;
    end else begin
      core_valid_in <= grant_vld;
      if (grant_vld) begin
        rr_ptr              <= grant_id;
        core_plan_text_128  <= req_text[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        core_cipher_key_128 <= req_key[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        core_flag           <= req_flag[grant_id];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_vld) core_id_p0 <= grant_id;
  end

  // Stage p1: tag pipe, last stage lines up with core_cipher_text_128
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p1 <= '0;
    end else begin
      tag_vld_p1[0] <= core_valid_in;
      for (int i = 1; i < CORE_LATENCY; i++) tag_vld_p1[i] <= tag_vld_p1[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id_p1[0]   <= core_id_p0;
    tag_flag_p1[0] <= core_flag;
    for (int i = 1; i < CORE_LATENCY; i++) begin
      tag_id_p1[i]   <= tag_id_p1[i-1];
      tag_flag_p1[i] <= tag_flag_p1[i-1];
    end
  end

  // Stage p2: response FIFO
  assign push      = tag_vld_p1[CORE_LATENCY-1];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
  assign rsp_flag  = rsp_valid & fifo_flag[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= core_cipher_text_128;
      fifo_id[wr_ptr]   <= tag_id_p1[CORE_LATENCY-1];
      fifo_flag[wr_ptr] <= tag_flag_p1[CORE_LATENCY-1];
    end
  end

`ifdef AES_SCHED_CHECK_EN
  logic exp_valid_out;
  assign exp_valid_out = tag_vld_p1[CORE_LATENCY-1] & tag_flag_p1[CORE_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (core_valid_out != exp_valid_out) begin
      err_sticky <= 1'b1;
    end
  end
`else
  logic unused_valid_out;
  assign unused_valid_out = core_valid_out;
  assign err_sticky       = 1'b0;
`endif

endmodule
